// File: rtl/vga_fifo_fetch_if.sv
// Bus-fetch and display-byte signal bundle for vga_fifo_fetch.
// master = the fetch block, slave = bus responder / display stage.
interface vga_fifo_fetch_if;
    logic [29:0] base_addr;
    logic        vga_vsync;
    logic        addr_strobe;
    logic [29:0] addr;
    logic        data_ready;
    logic [31:0] data_in;
    logic [7:0]  dispData;
    logic        rd;
    logic        underrun;

    modport master (
        input  base_addr, vga_vsync, data_ready, data_in, rd,
        output addr_strobe, addr, dispData, underrun
    );

    modport slave (
        output base_addr, vga_vsync, data_ready, data_in, rd,
        input  addr_strobe, addr, dispData, underrun
    );
endinterface

// File: rtl/vga_fifo_fetch.sv
// Framebuffer prefetch: reads FRAME_WORDS words per frame into a small FIFO and
// serves them one byte at a time. Optional sticky underrun flag: VGA_FIFO_UNDERRUN_FLAG_EN.
module vga_fifo_fetch #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 9600
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_fifo_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [WC_W-1:0]  WORDS_C = WC_W'(FRAME_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;
    state_t r_state, w_state_next;

    logic             r_vs_meta, r_vs_sync, r_vs_prev;
    logic             w_frame_start;
    logic [29:0]      r_addr, r_pend_base;
    logic [WC_W-1:0]  r_word_cnt, w_word_cnt_next;
    logic             r_frame_active;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [1:0]       r_byte_sel, w_byte_sel_next;
    logic [7:0]       r_disp, w_disp_next;
    logic [31:0]      w_head_next;
    logic             w_push, w_pop, w_advance, w_can_fetch, w_ack, w_strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_meta <= bus.vga_vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_frame_start = r_vs_prev & ~r_vs_sync;
    assign w_ack         = bus.data_ready && (r_state != S_IDLE);
    assign w_push        = (r_state == S_REQ) && bus.data_ready && !w_frame_start;
    assign w_advance     = bus.rd && (r_count != '0) && !w_frame_start;
    assign w_pop         = w_advance && (r_byte_sel == 2'd3);

    always_comb begin
        w_count_next    = r_count;
        w_word_cnt_next = r_word_cnt;
        w_byte_sel_next = r_byte_sel;
        if (w_frame_start) begin
            w_count_next    = '0;
            w_word_cnt_next = '0;
            w_byte_sel_next = 2'd0;
        end else begin
            if (w_push && !w_pop)
                w_count_next = r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                w_count_next = r_count - CNT_W'(1);
            if (w_push)
                w_word_cnt_next = r_word_cnt + WC_W'(1);
            if (w_advance)
                w_byte_sel_next = r_byte_sel + 2'd1;
        end
    end

    // dispData is registered, so pick the byte the FIFO will present after this edge.
    always_comb begin
        w_head_next = r_mem[r_rd_ptr];
        if (r_count == '0)
            w_head_next = bus.data_in;
        else if (w_pop)
            w_head_next = (r_count == CNT_W'(1)) ? bus.data_in : r_mem[r_rd_ptr + PTR_W'(1)];
        w_disp_next = 8'h00;
        if (!w_frame_start && (w_count_next != '0)) begin
            case (w_byte_sel_next)
                2'd0:    w_disp_next = w_head_next[7:0];
                2'd1:    w_disp_next = w_head_next[15:8];
                2'd2:    w_disp_next = w_head_next[23:16];
                default: w_disp_next = w_head_next[31:24];
            endcase
        end
    end

    // The post-push count already includes the word in flight, so REQ may chain into REQ.
    assign w_can_fetch = r_frame_active && !w_frame_start &&
                         (w_count_next < DEPTH_C) && (w_word_cnt_next < WORDS_C);

    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_fetch)
                    w_state_next = S_REQ;
            end
            S_REQ: begin
                w_strobe = 1'b1;
                if (bus.data_ready)
                    w_state_next = w_can_fetch ? S_REQ : S_IDLE;
                else if (w_frame_start)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_strobe = 1'b1;
                if (bus.data_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_pend_base    <= '0;
            r_frame_active <= 1'b0;
            r_word_cnt     <= '0;
            r_count        <= '0;
            r_byte_sel     <= 2'd0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_disp         <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_word_cnt <= w_word_cnt_next;
            r_count    <= w_count_next;
            r_byte_sel <= w_byte_sel_next;
            r_disp     <= w_disp_next;
            if (w_frame_start) begin
                r_frame_active <= 1'b1;
                r_wr_ptr       <= '0;
                r_rd_ptr       <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // A request still waiting for its ack keeps the old address; the new base waits aside.
            if (w_frame_start) begin
                if ((r_state != S_IDLE) && !bus.data_ready)
                    r_pend_base <= bus.base_addr;
                else
                    r_addr <= bus.base_addr;
            end else if (w_ack) begin
                r_addr <= (r_state == S_REQ) ? r_addr + 30'd1 : r_pend_base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.data_in;
    end

`ifdef VGA_FIFO_UNDERRUN_FLAG_EN
    logic r_underrun;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_underrun <= 1'b0;
        else if (w_frame_start)
            r_underrun <= 1'b0;
        else if (bus.rd && (r_count == '0))
            r_underrun <= 1'b1;
    end
    assign bus.underrun = r_underrun;
`else
    assign bus.underrun = 1'b0;
`endif

    assign bus.addr_strobe = w_strobe;
    assign bus.addr        = r_addr;
    assign bus.dispData    = r_disp;
endmodule

// File: doc/vga_fifo_fetch.md
VGA_FIFO_FETCH -- requirements
Module: vga_fifo_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, FIFO depth in 32-bit words; SHALL be a power of 2, minimum 4.
REQ-002 Parameter FRAME_WORDS, default 9600, words fetched per frame (640x480 at 1 bpp).
REQ-003 clk  in  1  CPU clock; the block SHALL use a single clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 base_addr  in  30  framebuffer word address; SHALL be sampled at each frame start.
REQ-006 vga_vsync  in  1  active-low vsync from the display stage, asynchronous to clk.
REQ-007 addr_strobe  out  1  bus read request.
REQ-008 addr  out  30  bus word address.
REQ-009 data_ready  in  1  bus acknowledge; data_in is valid in the same cycle.
REQ-010 data_in  in  32  bus read data.
REQ-011 dispData  out  8  current display byte.
REQ-012 rd  in  1  one-clk pulse: current byte consumed, advance.
REQ-013 underrun  out  1  sticky underrun flag (see Configuration).

Function
REQ-014 vga_vsync SHALL pass through a 2-flop synchronizer; a 1->0 edge on the synchronized signal is "frame start".
REQ-015 Frame start SHALL, in one cycle: flush the FIFO (count=0); set addr=base_addr; clear the word counter and byte select; set frame_active=1.
REQ-016 Fetch FSM states SHALL be IDLE, REQ and DRAIN.
REQ-017 IDLE->REQ when frame_active=1, FIFO count<FIFO_DEPTH (counting the outstanding word) and word counter<FRAME_WORDS.
REQ-018 In REQ, addr_strobe=1 and addr SHALL be held until data_ready=1.
REQ-019 On data_ready in REQ: push data_in; addr+1; word counter+1; return to IDLE. Back-to-back requests SHALL be allowed from the next cycle.
REQ-020 Frame start while in REQ SHALL enter DRAIN: strobe and the old addr are held until data_ready, the data is discarded, then the FSM goes to IDLE with the new frame state.
REQ-021 When the word counter reaches FRAME_WORDS, no further requests SHALL be issued until the next frame start.
REQ-022 dispData SHALL be byte[byte_sel] of the FIFO head word, with byte 0 = bits 7:0, emitted first. dispData SHALL be registered and valid 1 clk after a push into an empty FIFO.
REQ-023 rd with FIFO non-empty SHALL advance byte_sel; rd at byte_sel=3 SHALL pop the head word and set byte_sel=0.
REQ-024 rd with FIFO empty is an underrun: no pop, byte_sel unchanged, dispData=0x00.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged. A push when full SHALL be impossible by REQ-017.
REQ-026 rd coincident with frame start: flush SHALL win and rd SHALL be ignored.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH. addr SHALL wrap modulo 2^30.

Reset
REQ-028 When reset_n=0: addr_strobe=0, addr=0, dispData=0x00, underrun=0, FSM=IDLE, count=0, byte_sel=0, word counter=0, frame_active=0, synchronizer flops=1.
REQ-029 Reset mid-transaction SHALL drop addr_strobe immediately. After reset, no fetch SHALL occur before the first frame start.

Configuration
REQ-030 Macro VGA_FIFO_UNDERRUN_FLAG_EN defined: underrun SHALL be set on any REQ-024 event and cleared only by reset or frame start.
REQ-031 Macro VGA_FIFO_UNDERRUN_FLAG_EN undefined: underrun SHALL be tied to 0 and no flag register SHALL exist; all other behaviour is identical.

Verification
REQ-032 base_addr=0x100, vsync pulse, zero-wait ack, no rd -> 16 requests at addresses 0x100..0x10F, then addr_strobe stays 0.
REQ-033 Push 0x44332211, then 4 rd pulses -> dispData 0x11, 0x22, 0x33, 0x44; the 4th rd pops the word and count decrements.
REQ-034 FIFO empty, rd pulse -> dispData=0x00, underrun=1 (macro on) or 0 (macro off); byte_sel unchanged.
REQ-035 Frame start while strobe is held and ack is delayed 5 clk -> strobe held at the old addr, the acked data is not pushed, then the next request is at the new base_addr.
REQ-036 FRAME_WORDS=20, continuous rd -> exactly 20 requests, then none until the next vsync edge.
REQ-037 reset_n low during REQ -> addr_strobe=0 and dispData=0x00 in the same cycle; no request issued before the next vsync edge.
